// File: rtl/if_fetch_bpred.sv
// Instruction-fetch stage with an integrated bimodal branch predictor.
// Owns the program counter, drives the instruction ROM address and loads the
// IF/ID pipeline register with PC+4, the fetched word and a prediction bit.
// Optional feature macro: BPRED_EN. When it is defined, a table of two-bit
// saturating counters steers fetch to predicted-taken branch targets.
// Without it, fetch is purely sequential apart from redirects.
module if_fetch_bpred #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BHT_BITS = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pcPlus4IFID,
    output logic [31:0] instructionROMOutIFID,
    output logic        predictionIFID
);

    // Fetch stage (p0): current PC and values derived from it
    logic [31:0] pc_p0;
    logic [31:0] pc_plus4_p0;
    logic [31:0] next_pc_p0;
    logic        pred_p0;

    assign imem_addr   = pc_p0;
    assign pc_plus4_p0 = pc_p0 + 32'd4;

`ifdef BPRED_EN
    localparam int BHT_N = 1 << BHT_BITS;

    logic [1:0]          bht [BHT_N];
    logic [BHT_BITS-1:0] rd_idx;
    logic [BHT_BITS-1:0] upd_idx;
    logic                is_branch_p0;
    logic [31:0]         branch_target_p0;
    logic                unused_upd_pc;

    // Two-bit saturating counter step toward the observed outcome
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'b01;
        else
            return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign rd_idx        = pc_p0[BHT_BITS+1:2];
    assign upd_idx       = upd_pc[BHT_BITS+1:2];
    assign unused_upd_pc = ^{upd_pc[31:BHT_BITS+2], upd_pc[1:0]};

    // Conditional branch decode: REGIMM, beq, bne, blez, bgtz
    always_comb begin
        is_branch_p0 = 1'b0;
        case (imem_data[31:26])
            6'd1, 6'd4, 6'd5, 6'd6, 6'd7: is_branch_p0 = 1'b1;
            default:                      is_branch_p0 = 1'b0;
        endcase
    end

    assign branch_target_p0 = pc_plus4_p0 +
                              {{14{imem_data[15]}}, imem_data[15:0], 2'b00};

    // Read sees the pre-update counter; a same-cycle write lands at the edge
    assign pred_p0 = is_branch_p0 & bht[rd_idx][1];

    // BHT training; reset returns every entry to weakly not-taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_N; i++)
                bht[i] <= 2'b01;
        end else if (upd_valid) begin
            bht[upd_idx] <= ctr_next(bht[upd_idx], upd_taken);
        end
    end

    // Next-PC select: redirect beats stall, stall beats prediction
    always_comb begin
        next_pc_p0 = pc_plus4_p0;
        if (redirect_valid)
            next_pc_p0 = redirect_pc;
        else if (stall)
            next_pc_p0 = pc_p0;
        else if (pred_p0)
            next_pc_p0 = branch_target_p0;
    end
`else
    localparam int unused_bht_bits = BHT_BITS;
    logic          unused_upd;

    assign unused_upd = ^{upd_valid, upd_pc, upd_taken};
    assign pred_p0    = 1'b0;

    // Next-PC select without prediction: redirect, hold, or sequential
    always_comb begin
        next_pc_p0 = pc_plus4_p0;
        if (redirect_valid)
            next_pc_p0 = redirect_pc;
        else if (stall)
            next_pc_p0 = pc_p0;
    end
`endif

    // Program counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pc_p0 <= RESET_PC;
        else
            pc_p0 <= next_pc_p0;
    end

    // IF/ID boundary (p1): bubble on redirect, hold on stall, else load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pcPlus4IFID           <= 32'd0;
            instructionROMOutIFID <= 32'd0;
            predictionIFID        <= 1'b0;
        end else if (redirect_valid) begin
            pcPlus4IFID           <= 32'd0;
            instructionROMOutIFID <= 32'd0;
            predictionIFID        <= 1'b0;
        end else if (!stall) begin
            pcPlus4IFID           <= pc_plus4_p0;
            instructionROMOutIFID <= imem_data;
            predictionIFID        <= pred_p0;
        end
    end

endmodule

// File: tb/tb_if_fetch_bpred.sv
// Directed bench for if_fetch_bpred with a small address-keyed ROM model.
// Prediction-dependent expectations follow whether BPRED_EN is defined.
module tb_if_fetch_bpred;

`ifdef BPRED_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pcPlus4IFID;
    logic [31:0] instructionROMOutIFID;
    logic        predictionIFID;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_bpred #(.RESET_PC(32'h0000_0100), .BHT_BITS(6)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .stall                 (stall),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .upd_valid             (upd_valid),
        .upd_pc                (upd_pc),
        .upd_taken             (upd_taken),
        .imem_addr             (imem_addr),
        .imem_data             (imem_data),
        .pcPlus4IFID           (pcPlus4IFID),
        .instructionROMOutIFID (instructionROMOutIFID),
        .predictionIFID        (predictionIFID)
    );

    always #5 clock = ~clock;

    // ROM: beq +4 at 0x200, beq -1 at 0x0, addi tagged with the address elsewhere
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0200: return 32'h1000_0004;
            32'h0000_0000: return 32'h1000_FFFF;
            default:       return {8'h20, a[23:0]};
        endcase
    endfunction

    always_comb imem_data = rom(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic train(input logic [31:0] a, input logic taken, input int n);
        upd_valid = 1'b1;
        upd_pc    = a;
        upd_taken = taken;
        repeat (n) step();
        upd_valid = 1'b0;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] p4,
                            input logic [31:0] ins, input logic pr);
        chk({tag, "_pc4"},  pcPlus4IFID, p4);
        chk({tag, "_ins"},  instructionROMOutIFID, ins);
        chk({tag, "_pred"}, {31'd0, predictionIFID}, {31'd0, pr});
    endtask

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        upd_valid      = 1'b0;
        upd_pc         = 32'd0;
        upd_taken      = 1'b0;

        // Reset state
        repeat (2) step();
        chk("rst_pc", imem_addr, 32'h100);
        chk_ifid("rst", 32'd0, 32'd0, 1'b0);

        // Sequential fetch from RESET_PC
        reset = 1'b0;
        step();
        chk("seq_pc1", imem_addr, 32'h104);
        chk_ifid("seq1", 32'h104, 32'h2000_0100, 1'b0);
        step();
        chk("seq_pc2", imem_addr, 32'h108);
        chk("seq2_pc4", pcPlus4IFID, 32'h108);

        // Redirect to untrained branch: bubble, then not-taken fetch
        redirect_to(32'h200);
        chk("redir_pc", imem_addr, 32'h200);
        chk_ifid("bubble", 32'd0, 32'd0, 1'b0);
        step();
        chk("untrained_pc", imem_addr, 32'h204);
        chk_ifid("untrained", 32'h204, 32'h1000_0004, 1'b0);

        // Two taken updates, then refetch: predicted taken to 0x214
        train(32'h200, 1'b1, 2);
        redirect_to(32'h200);
        step();
        chk("trained_pc", imem_addr, BP ? 32'h214 : 32'h204);
        chk_ifid("trained", 32'h204, 32'h1000_0004, BP);

        // Saturate high, one not-taken: counter 2, still taken
        train(32'h200, 1'b1, 5);
        train(32'h200, 1'b0, 1);
        redirect_to(32'h200);
        step();
        chk("sat_hi_pc", imem_addr, BP ? 32'h214 : 32'h204);
        chk("sat_hi_pred", {31'd0, predictionIFID}, {31'd0, BP});

        // Saturate low, one taken: counter 1, not taken
        train(32'h200, 1'b0, 4);
        train(32'h200, 1'b1, 1);
        redirect_to(32'h200);
        step();
        chk("sat_lo_pc", imem_addr, 32'h204);
        chk("sat_lo_pred", {31'd0, predictionIFID}, 32'd0);

        // Stall and redirect together: redirect wins
        stall = 1'b1;
        redirect_to(32'h400);
        chk("stall_redir_pc", imem_addr, 32'h400);
        chk_ifid("stall_redir", 32'd0, 32'd0, 1'b0);
        stall = 1'b0;
        step();
        chk("post_redir_pc", imem_addr, 32'h404);
        chk("post_redir_ins", instructionROMOutIFID, 32'h2000_0400);

        // Stall alone holds PC and IF/ID every cycle
        stall = 1'b1;
        step();
        chk("stall1_pc", imem_addr, 32'h404);
        chk("stall1_pc4", pcPlus4IFID, 32'h404);
        step();
        chk("stall2_pc", imem_addr, 32'h404);
        chk_ifid("stall2", 32'h404, 32'h2000_0400, 1'b0);
        stall = 1'b0;
        step();
        chk("unstall_pc", imem_addr, 32'h408);

        // PC wrap, while training index 0 to strongly taken
        upd_valid      = 1'b1;
        upd_pc         = 32'h0;
        upd_taken      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_top_pc", imem_addr, 32'hFFFF_FFFC);
        step();
        upd_valid = 1'b0;
        chk("wrap_pc", imem_addr, 32'h0);
        chk_ifid("wrap", 32'h0, 32'h20FF_FFFC, 1'b0);

        // Negative-offset branch at 0 predicted taken targets 0
        step();
        chk("neg_br_pc", imem_addr, BP ? 32'h0 : 32'h4);
        chk_ifid("neg_br", 32'h4, 32'h1000_FFFF, BP);

        // Asynchronous mid-cycle reset clears PC, IF/ID and BHT history
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pc", imem_addr, 32'h100);
        chk_ifid("arst", 32'd0, 32'd0, 1'b0);
        #1;
        reset = 1'b0;
        redirect_to(32'h0);
        step();
        chk("arst_bht_pc", imem_addr, 32'h4);
        chk("arst_bht_pred", {31'd0, predictionIFID}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
